multicycle_exec_unit: RTL
=========================

// Module: multicycle_exec_unit
// PURPOSE
//  Parametrised multicycle successor to the single-cycle regfile/ALU/data-memory datapath.
//  Accepts one decoded MIPS-style instruction per valid/ready handshake.
//  Sequences it through a READ/EXEC/MEM/WB state machine, with configurable memory wait states.
//  Sits between the decode stage and the register/memory state; owns both the register file and the data memory.
// PARAMETERS
//  DATA_W     32  datapath, register and memory word width
//  REG_CNT    32  number of registers; index width RA_W = $clog2(REG_CNT); reg 0 reads 0, writes ignored
//  MEM_DEPTH  256 data memory words; byte address, word index = addr[...:2]
//  MEM_LAT    2   extra wait cycles spent in MEM for lw/sw (0 allowed)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       instruction offered
//  in_ready   out  1       unit can accept (state IDLE)
//  op_class   in   2       0=R-type, 1=addi, 2=lw, 3=sw
//  funct      in   6       R-type function: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt
//  rs,rt,rd   in   RA_W    register indices
//  imm        in   16      immediate, sign-extended to DATA_W
//  done       out  1       one-cycle pulse in the cycle after the instruction retires
//  result     out  DATA_W  ALU result (or load data for lw), held until next done
//  zero       out  1       result==0, updated with result
//  err        out  1       sticky: illegal funct or out-of-range address; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; done=0; result=0; zero=1; err=0; all registers 0; memory contents undefined.
//  Handshake: accept on in_valid&&in_ready; all inputs captured into an internal instruction register that cycle.
//   in_ready=0 from the next cycle until return to IDLE.
//  FSM:
//   IDLE -accept-> READ -> EXEC -> (lw/sw ? MEM : WB).
//   MEM holds MEM_LAT+1 cycles, counted by an internal down-counter, then -> WB. WB -> IDLE.
//   READ latches A=R[rs] and B=R[rt].
//   EXEC computes ALU_out.
//     Operand 2 is sext(imm) for op 1/2/3, else B.
//     ALU ops: add/sub wrap modulo 2^DATA_W; slt is a signed compare giving 1/0; lw/sw/addi use add.
//   MEM:
//     Word index = ALU_out>>2; low 2 bits ignored.
//     Index >= MEM_DEPTH: err<=1, store suppressed, load data=0.
//     sw writes B on the final MEM cycle only. lw samples memory on the final MEM cycle.
//   WB:
//     R-type writes rd; addi and lw write rt. sw writes nothing.
//     Writes to reg 0 are dropped.
//     result/zero updated; done=1 in the following cycle (IDLE).
//  Latency: accept to done = 4 cycles (R/addi), 5+MEM_LAT cycles (lw/sw).
//   Back-to-back accept is possible in the same cycle done is high.
//  Illegal funct: err<=1 in EXEC, no writeback, done still pulses, result unchanged.
//  Hazards: none possible; one instruction in flight. A WB write is visible to the next READ.
//  Reset mid-operation: FSM returns to IDLE immediately; pending store/writeback abandoned; no done pulse.
//  in_valid while busy is ignored; the upstream must hold it.
// TESTING
//  1. reset, addi r1,r0,5; addi r2,r0,-3; R add r3,r1,r2 -> result=2, zero=0, done 4 cycles after each accept.
//  2. R sub r4,r1,r1 -> result=0, zero=1. R slt r5,r2,r1 -> result=1 (signed -3<5).
//  3. MEM_LAT=2: sw r1,8(r0) then lw r6,8(r0) -> r6=5.
//     done 7 cycles after each accept; in_ready low throughout.
//  4. lw r7,4*MEM_DEPTH(r0) -> err=1, r7=0. Following addi still executes; err stays 1.
//  5. addi r0,r0,7 then R or r8,r0,r0 -> result=0 (reg 0 immutable). funct=0x3F -> err=1, no write, done pulses.
//  6. Assert rst_n=0 during MEM of an sw -> in_ready=1 asynchronously, no done.
//     A later lw of that address does not return the abandoned data.

Source files
------------

// File: rtl/multicycle_exec_unit.sv
// Multicycle MIPS-style execute unit: READ/EXEC/MEM/WB sequencing over an owned
// register file and word-addressed data memory with configurable wait states.
module multicycle_exec_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_CNT   = 32,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned MEM_LAT   = 2,
    localparam int unsigned RA_W     = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_class,
    input  logic [5:0]        funct,
    input  logic [RA_W-1:0]   rs,
    input  logic [RA_W-1:0]   rt,
    input  logic [RA_W-1:0]   rd,
    input  logic [15:0]       imm,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              err
);

    localparam int unsigned MIDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W  = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

    localparam logic [1:0] OP_R    = 2'd0;
    localparam logic [1:0] OP_LW   = 2'd2;
    localparam logic [1:0] OP_SW   = 2'd3;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_WB} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_final_c;

    logic [1:0]        op_q;
    logic [5:0]        funct_q;
    logic [RA_W-1:0]   rs_q, rt_q, rd_q;
    logic [15:0]       imm_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic              ill_q;

    logic              in_ready_q, done_q, zero_q, err_q;
    logic [DATA_W-1:0] result_q;

    logic [DATA_W-1:0] rf_q  [REG_CNT];
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [DATA_W-1:0] op2_c, alu_c;
    logic              ill_c;
    logic              in_range_c;
    logic [MIDX_W-1:0] mem_idx_c;
    logic [RA_W-1:0]   wr_idx_c;

    assign in_ready = in_ready_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign err      = err_q;

    // State register and MEM wait-state counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_final_c = 1'b0;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_READ;
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                state_d = (op_q[1]) ? S_MEM : S_WB;
                cnt_d   = CNT_W'(MEM_LAT);
            end
            S_MEM: begin
                if (cnt_q == '0) begin
                    mem_final_c = 1'b1;
                    state_d     = S_WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU: immediate ops all add; unknown R-type funct flags illegal
    always_comb begin
        op2_c = (op_q == OP_R) ? b_q : {{(DATA_W-16){imm_q[15]}}, imm_q};
        alu_c = a_q + op2_c;
        ill_c = 1'b0;
        if (op_q == OP_R) begin
            case (funct_q)
                F_ADD:   alu_c = a_q + op2_c;
                F_SUB:   alu_c = a_q - op2_c;
                F_AND:   alu_c = a_q & op2_c;
                F_OR:    alu_c = a_q | op2_c;
                F_SLT:   alu_c = ($signed(a_q) < $signed(op2_c)) ? DATA_W'(1) : '0;
                default: ill_c = 1'b1;
            endcase
        end
    end

    assign in_range_c = (res_q >> 2) < DATA_W'(MEM_DEPTH);
    assign mem_idx_c  = res_q[MIDX_W+1:2];
    assign wr_idx_c   = (op_q == OP_R) ? rd_q : rt_q;

    // Datapath, register file and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            funct_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            ill_q      <= 1'b0;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(REG_CNT); i++) rf_q[i] <= '0;
        end else begin
            done_q     <= 1'b0;
            in_ready_q <= (state_d == S_IDLE);
            if (state_q == S_IDLE && in_valid) begin
                op_q    <= op_class;
                funct_q <= funct;
                rs_q    <= rs;
                rt_q    <= rt;
                rd_q    <= rd;
                imm_q   <= imm;
            end
            if (state_q == S_READ) begin
                a_q <= rf_q[rs_q];
                b_q <= rf_q[rt_q];
            end
            if (state_q == S_EXEC) begin
                res_q <= alu_c;
                ill_q <= ill_c;
                if (ill_c) err_q <= 1'b1;
            end
            if (mem_final_c) begin
                if (!in_range_c) err_q <= 1'b1;
                if (op_q == OP_LW) res_q <= in_range_c ? mem_q[mem_idx_c] : '0;
            end
            if (state_q == S_WB) begin
                done_q <= 1'b1;
                if (!ill_q) begin
                    result_q <= res_q;
                    zero_q   <= (res_q == '0);
                    if (op_q != OP_SW && wr_idx_c != '0) rf_q[wr_idx_c] <= res_q;
                end
            end
        end
    end

    // Data memory has no reset; stores commit only on the last MEM cycle
    always_ff @(posedge clk) begin
        if (mem_final_c && op_q == OP_SW && in_range_c) mem_q[mem_idx_c] <= b_q;
    end

endmodule
